// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters sharing one datapath select.
// A grant ends on release, on the owner dropping its request, or after MAX_HOLD cycles.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] req_i,
  input  logic       release_i,
  output logic [7:0] grant_o,
  output logic [2:0] grant_idx_o,
  output logic       grant_valid_o,
  output logic       timeout_o
);

  // state | meaning
  // IDLE  | no owner; arbitrate among req_i starting at ptr
  // GRANT | idx owns the resource; watch for release, drop or hold limit
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] grant_q, grant_d;
  logic       timeout_q, timeout_d;

  logic       found;
  logic [2:0] winner;
  logic [2:0] cand;
  logic       end_rel, end_drop, end_max;

  // First set request at or after ptr, wrapping mod 8.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    cand   = '0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign end_rel  = release_i;
  assign end_drop = ~req_i[idx_q];
  assign end_max  = (hold_q == MAX_HOLD_C);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          idx_d   = winner;
          grant_d = 8'b1 << winner;
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        if (end_rel || end_drop || end_max) begin
          state_d   = IDLE;
          grant_d   = '0;
          ptr_d     = idx_q + 3'd1;
          timeout_d = end_max && !end_rel && !end_drop;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = idx_q;
  assign grant_valid_o = (state_q == GRANT);
  assign timeout_o     = timeout_q;

endmodule
